// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Nominal 640x480p60 raster constants shared by the timing
//                generator and the capture block, plus the capture FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_PORCH  = 48;
    localparam int H_TOTAL  = 800;
    // Capture alignment: first hsync-high sample to x=0 (porch plus one
    // clock of slack for data/sync skew)
    localparam int H_BACK   = 49;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = 525;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_edge
//  Description : Two-register pipeline for one active-low sync line with a
//                rising-edge (end of sync pulse) detector. Registers idle
//                high so leaving reset never looks like an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_edge (
    input  logic clk_pix,
    input  logic rst_pix_n,
    input  logic sync_in,
    output logic sync_rise
);

    logic r_s1;
    logic r_s2;

    // Two-stage sample of the sync line, idle level after reset
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= sync_in;
            r_s2 <= r_s1;
        end
    end

    assign sync_rise = r_s1 & ~r_s2;

endmodule
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : vga_capture
//  Description : Samples a 2-2-2 RGB VGA stream, recovers pixel coordinates
//                from the syncs, verifies line/frame timing and emits a
//                validated pixel stream with a fixed two-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int H_BACK   = vga_pkg::H_BACK,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int V_BACK   = vga_pkg::V_BACK
) (
    input  logic        clk_pix,
    input  logic        rst_pix_n,
    input  logic [1:0]  vga_r,
    input  logic [1:0]  vga_g,
    input  logic [1:0]  vga_b,
    input  logic        hsync,
    input  logic        vsync,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [10:0] line_period
);
    import vga_pkg::*;

    localparam logic [10:0] c_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] c_TIMEOUT = 11'(2 * H_TOTAL);
    localparam logic [10:0] c_V_TOTAL = 11'(V_TOTAL);
    localparam logic [10:0] c_H_BACK  = 11'(H_BACK);
    localparam logic [10:0] c_H_END   = 11'(H_BACK + H_ACTIVE);
    localparam logic [9:0]  c_V_BACK  = 10'(V_BACK);
    localparam logic [9:0]  c_V_END   = 10'(V_BACK + V_ACTIVE);

    logic        w_h_rise;
    logic        w_v_rise;
    logic [5:0]  r_rgb_s1;
    logic [5:0]  r_rgb_s2;
    logic [10:0] r_hcnt;
    logic [9:0]  r_lcnt;
    logic        r_first;
    logic        r_bad;
    logic        r_err;
    cap_state_t  r_state;
    cap_state_t  w_state_next;
    logic        w_bad_next;
    logic        w_err;

    vga_sync_edge u_hs_edge (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .sync_in   (hsync),
        .sync_rise (w_h_rise)
    );

    vga_sync_edge u_vs_edge (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .sync_in   (vsync),
        .sync_rise (w_v_rise)
    );

    // hcnt+1 saturating; doubles as the period measured at an hsync edge
    logic [10:0] w_hcnt_inc;
    logic [10:0] w_hcnt_next;
    assign w_hcnt_inc  = (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;
    assign w_hcnt_next = w_h_rise ? 11'd0 : w_hcnt_inc;

    logic w_period_bad;
    logic w_frame_bad;
    logic w_timeout;
    assign w_period_bad = w_h_rise && (w_hcnt_inc != c_H_TOTAL);
    assign w_frame_bad  = w_v_rise && (({1'b0, r_lcnt} + 11'd1) != c_V_TOTAL);
    assign w_timeout    = (w_hcnt_next == c_TIMEOUT);

    // Colour pipeline aligned with the counter stage
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_rgb_s1 <= 6'd0;
            r_rgb_s2 <= 6'd0;
        end else begin
            r_rgb_s1 <= {vga_r, vga_g, vga_b};
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    // Pixel/line counters and line period measurement
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hcnt      <= 11'd0;
            r_lcnt      <= 10'd0;
            r_first     <= 1'b0;
            line_period <= 11'd0;
        end else begin
            r_hcnt <= w_hcnt_next;
            if (w_h_rise) begin
                line_period <= w_hcnt_inc;
            end
            // A vsync edge arms the next hsync edge to be line 0; when both
            // arrive together the hsync edge itself is line 0.
            if (w_v_rise) begin
                r_lcnt  <= 10'd0;
                r_first <= ~w_h_rise;
            end else if (w_h_rise) begin
                if (r_first) begin
                    r_lcnt <= 10'd0;
                end else if (r_lcnt != 10'h3FF) begin
                    r_lcnt <= r_lcnt + 10'd1;
                end
                r_first <= 1'b0;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state <= ST_HUNT;
            r_bad   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bad   <= w_bad_next;
            r_err   <= w_err;
        end
    end

    // Lock FSM next state; timeout overrides every other decision
    always_comb begin
        w_state_next = r_state;
        w_bad_next   = r_bad;
        w_err        = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_v_rise) begin
                    w_state_next = ST_CHECK;
                    w_bad_next   = 1'b0;
                end
            end
            ST_CHECK: begin
                if (w_v_rise) begin
                    if (!(r_bad || w_period_bad) && !w_frame_bad) begin
                        w_state_next = ST_LOCKED;
                    end
                    w_bad_next = 1'b0;
                end else if (w_period_bad) begin
                    w_bad_next = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_period_bad || w_frame_bad) begin
                    w_state_next = ST_HUNT;
                    w_err        = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
        if (w_timeout) begin
            w_state_next = ST_HUNT;
            w_bad_next   = 1'b1;
            w_err        = (r_state == ST_LOCKED);
        end
    end

    logic       w_active;
    logic [9:0] w_x;
    logic [9:0] w_y;
    assign w_x      = 10'(r_hcnt - c_H_BACK);
    assign w_y      = r_lcnt - c_V_BACK;
    assign w_active = (r_hcnt >= c_H_BACK) && (r_hcnt < c_H_END) &&
                      (r_lcnt >= c_V_BACK) && (r_lcnt < c_V_END) &&
                      (r_state == ST_LOCKED);

    // Registered pixel stream and status outputs
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 6'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            locked   <= (r_state == ST_LOCKED);
            sync_err <= r_err;
            if (w_active) begin
                pix_valid   <= 1'b1;
                pix_x       <= w_x;
                pix_y       <= w_y;
                pix_rgb     <= r_rgb_s2;
                frame_start <= (w_x == 10'd0) && (w_y == 10'd0);
            end else begin
                pix_valid   <= 1'b0;
                pix_rgb     <= 6'd0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_capture
//  Description : Directed bench for vga_capture on a scaled-down raster
//                (32x12 total, 16x6 active) so whole frames stay short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

    localparam int HA = 16;
    localparam int HT = 32;
    localparam int HB = 5;
    localparam int VA = 6;
    localparam int VT = 12;
    localparam int VB = 3;

    logic        clk_pix   = 1'b0;
    logic        rst_pix_n = 1'b0;
    logic [1:0]  vga_r = 2'd0;
    logic [1:0]  vga_g = 2'd0;
    logic [1:0]  vga_b = 2'd0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [5:0]  pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [10:0] line_period;

    int n_compared   = 0;
    int n_mismatched = 0;

    vga_capture #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .H_BACK   (HB),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT),
        .V_BACK   (VB)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .line_period (line_period)
    );

    always #5 clk_pix = ~clk_pix;

    // Running tallies of the output stream, sampled on the falling edge
    int         valid_cnt = 0;
    int         fs_cnt    = 0;
    int         fs_bad    = 0;
    int         rgb_bad   = 0;
    int         se_cnt    = 0;
    logic [9:0] last_x    = 10'd0;
    logic [9:0] last_y    = 10'd0;
    logic [5:0] w_sum;
    assign w_sum = pix_x[5:0] + pix_y[5:0];

    always @(negedge clk_pix) begin
        if (pix_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_x    <= pix_x;
            last_y    <= pix_y;
            if (pix_rgb !== w_sum) rgb_bad <= rgb_bad + 1;
        end else if (pix_rgb !== 6'd0) begin
            rgb_bad <= rgb_bad + 1;
        end
        if (frame_start) begin
            fs_cnt <= fs_cnt + 1;
            if (!pix_valid || pix_x != 10'd0 || pix_y != 10'd0) fs_bad <= fs_bad + 1;
        end
        if (sync_err) se_cnt <= se_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_value({pfx, "_pix_valid"},   pix_valid,   0);
        check_value({pfx, "_pix_x"},       pix_x,       0);
        check_value({pfx, "_pix_y"},       pix_y,       0);
        check_value({pfx, "_pix_rgb"},     pix_rgb,     0);
        check_value({pfx, "_frame_start"}, frame_start, 0);
        check_value({pfx, "_locked"},      locked,      0);
        check_value({pfx, "_sync_err"},    sync_err,    0);
        check_value({pfx, "_line_period"}, line_period, 0);
    endtask

    // Per-line observations two and three cycles after each line start
    logic        lk2 [0:15];
    logic        lk3 [0:15];
    logic        se2 [0:15];
    logic        se3 [0:15];
    logic [10:0] lp3 [0:15];

    // Drive lines v0..nlines-1; line long_v gets one extra clock; reset is
    // pulsed during line rst_v. The last two lines carry vsync low.
    task automatic run_frame(input int v0, input int nlines, input int long_v, input int rst_v);
        for (int v = v0; v < nlines; v++) begin
            int len;
            len = (v == long_v) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                @(posedge clk_pix);
                #1;
                hsync = (h < len - 4);
                vsync = (v < nlines - 2);
                if (h >= HB && h < HB + HA && v >= VB && v < VB + VA)
                    {vga_r, vga_g, vga_b} = 6'((h - HB) + (v - VB));
                else
                    {vga_r, vga_g, vga_b} = 6'h2A;
                if (h == 2) begin
                    lk2[v] = locked;
                    se2[v] = sync_err;
                end
                if (h == 3) begin
                    lk3[v] = locked;
                    se3[v] = sync_err;
                    lp3[v] = line_period;
                end
                if (v == rst_v && h == 10) begin
                    check_value("pre_reset_valid", pix_valid, 1);
                    rst_pix_n = 1'b0;
                    #1;
                    check_all_zero("mid_reset");
                end
                if (v == rst_v && h == 20) rst_pix_n = 1'b1;
            end
        end
    endtask

    logic hl_lk [0:2];
    logic hl_se [0:2];

    // Both syncs held high; records status around sample 2*HT
    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pix);
            #1;
            hsync = 1'b1;
            vsync = 1'b1;
            {vga_r, vga_g, vga_b} = 6'h15;
            if (i >= 2 * HT + 2 && i <= 2 * HT + 4) begin
                hl_lk[i - (2 * HT + 2)] = locked;
                hl_se[i - (2 * HT + 2)] = sync_err;
            end
        end
    endtask

    int s_valid;
    int s_fs;
    int s_se;

    task automatic snap();
        s_valid = valid_cnt;
        s_fs    = fs_cnt;
        s_se    = se_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clk_pix);
        #1;
        check_all_zero("reset");
        rst_pix_n = 1'b1;

        // Clean raster: first vsync edge starts the check, second locks
        run_frame(4, VT, -1, -1);
        run_frame(0, VT, -1, -1);
        check_value("f1_locked", lk3[0], 0);
        snap();
        run_frame(0, VT, -1, -1);
        check_value("lock_t1", lk2[0], 0);
        check_value("lock_t2", lk3[0], 1);
        check_value("f2_valid", valid_cnt - s_valid, HA * VA);
        check_value("f2_fs", fs_cnt - s_fs, 1);
        snap();
        run_frame(0, VT, -1, -1);
        check_value("f3_valid", valid_cnt - s_valid, HA * VA);
        check_value("f3_fs", fs_cnt - s_fs, 1);
        check_value("f3_last_x", last_x, HA - 1);
        check_value("f3_last_y", last_y, VA - 1);
        check_value("f3_period", lp3[5], HT);
        check_value("f3_sync_err", se_cnt - s_se, 0);

        // One long line in the middle of the active area
        snap();
        run_frame(0, VT, 5, -1);
        check_value("long_se_pre", se2[6], 0);
        check_value("long_lk_pre", lk2[6], 1);
        check_value("long_se", se3[6], 1);
        check_value("long_lk", lk3[6], 0);
        check_value("long_period", lp3[6], HT + 1);
        check_value("long_se_cnt", se_cnt - s_se, 1);
        check_value("long_valid", valid_cnt - s_valid, HA * 3);
        run_frame(0, VT, -1, -1);
        check_value("long_relock_chk", lk3[0], 0);
        snap();
        run_frame(0, VT, -1, -1);
        check_value("long_relock", lk3[0], 1);
        check_value("long_relock_valid", valid_cnt - s_valid, HA * VA);

        // Short frame: one line missing
        run_frame(0, VT - 1, -1, -1);
        snap();
        run_frame(0, VT, -1, -1);
        check_value("short_lk_pre", lk2[0], 1);
        check_value("short_se", se3[0], 1);
        check_value("short_lk", lk3[0], 0);
        check_value("short_se_cnt", se_cnt - s_se, 1);
        check_value("short_valid", valid_cnt - s_valid, 0);
        run_frame(0, VT, -1, -1);
        check_value("short_relock_chk", lk3[0], 0);
        run_frame(0, VT, -1, -1);
        check_value("short_relock", lk3[0], 1);

        // Missing hsync while locked
        snap();
        hold_high(2 * HT + 16);
        check_value("to_lk_pre", hl_lk[0], 1);
        check_value("to_se_pre", hl_se[0], 0);
        check_value("to_lk", hl_lk[1], 0);
        check_value("to_se", hl_se[1], 1);
        check_value("to_se_post", hl_se[2], 0);
        check_value("to_se_cnt", se_cnt - s_se, 1);
        run_frame(4, VT, -1, -1);
        run_frame(0, VT, -1, -1);
        run_frame(0, VT, -1, -1);
        check_value("to_relock", lk3[0], 1);

        // Asynchronous reset mid-line while locked
        snap();
        run_frame(0, VT, -1, 5);
        run_frame(0, VT, -1, -1);
        check_value("rst_no_early_lock", lk3[0], 0);
        run_frame(0, VT, -1, -1);
        check_value("rst_relock", lk3[0], 1);
        check_value("rst_se_cnt", se_cnt - s_se, 0);

        // Whole-run stream consistency
        check_value("fs_position", fs_bad, 0);
        check_value("rgb_stream", rgb_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the 640x480p60 timing generator: samples an incoming 2-2-2 RGB VGA stream (negative-polarity hsync/vsync) in the pixel clock domain and recovers pixel coordinates. It checks line and frame timing against the nominal raster and emits a validated pixel stream for loopback checking, frame grabbing or downstream processing. It sits at the VGA input pins or on the internal loopback path, clocked by the same `clk_pix`.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_TOTAL`, 800: clocks per line
- `H_BACK`, 49: clocks from first hsync-high sample to pixel x=0; absorbs data/sync skew
- `V_ACTIVE`, 480: active lines per frame
- `V_TOTAL`, 525: lines per frame
- `V_BACK`, 33: hsync rising edges after vsync rising edge before line y=0
- `clk_pix` input 1: pixel clock
- `rst_pix_n` input 1: asynchronous, active-low reset
- `vga_r`, `vga_g`, `vga_b` input 2 each: colour inputs
- `hsync`, `vsync` input 1 each: active-low syncs
- `pix_valid` output 1: active pixel present, only while locked
- `pix_x`, `pix_y` output 10 each: coordinates of `pix_rgb`
- `pix_rgb` output 6: {r,g,b}
- `frame_start` output 1: one-cycle pulse coincident with pixel (0,0)
- `locked` output 1: timing verified
- `sync_err` output 1: one-cycle pulse on timing violation while locked
- `line_period` output 11: last measured hsync rising-to-rising period, saturating at 2047

## Operation
- Input stage: all inputs registered once (s1); syncs registered again (s2). The rising edge of a sync is s1=1, s2=0. Sync registers reset to 1 (idle), so reset never produces an edge.
- `hcnt` (11b): cleared to 0 on an hsync rising edge, otherwise increments, saturating at 2047. `line_period` loads `hcnt+1` on each hsync rising edge.
- `lcnt` (10b): cleared on a vsync rising edge. Increments on each hsync rising edge and saturates at 1023. The first hsync edge after a vsync edge gives lcnt=0.
- Coordinates: sample with `hcnt = H_BACK + x`, `x < H_ACTIVE`, and `lcnt = V_BACK + y`, `y < V_ACTIVE`, is active pixel (x,y).
- FSM with states HUNT, CHECK, LOCKED:
  - HUNT → CHECK on a vsync rising edge.
  - CHECK: a `bad` flag is set if any `line_period` ≠ H_TOTAL. At the next vsync edge:
    - if `!bad` and lcnt+1 == V_TOTAL, go to LOCKED;
    - otherwise stay in CHECK and clear `bad`.
  - LOCKED → HUNT, with a `sync_err` pulse, on any of:
    - `line_period` ≠ H_TOTAL;
    - vsync edge with lcnt+1 ≠ V_TOTAL;
    - timeout.
- Timeout: `hcnt` reaches 2*H_TOTAL in any state → HUNT, `bad` set, no error pulse unless LOCKED.
- Simultaneous hsync and vsync rising edges: the vsync rule is applied first, then the hsync edge counts as lcnt=0.
- `pix_valid`, `pix_x`, `pix_y`, `pix_rgb` and `frame_start` are registered. When not valid, `pix_rgb` = 0 and the coordinates hold their last values.
- Reset values: every output 0, FSM in HUNT, counters 0.

## Timing
- Input sample at cycle t appears on the `pix_*` outputs at t+2 (fixed latency).
- `locked` rises at t+2 after the vsync-high input sample that completes the check frame. With clean input from reset, that is the 2nd vsync rising edge seen.
- The first frame output after lock starts at the next (0,0) with `frame_start`.
- `locked` falls and `sync_err` pulses at t+2 after the offending sample. The pixel in that cycle is not valid.
- Reset assertion mid-frame clears all outputs asynchronously. After release, the block behaves as from power-up.

## Structure
- `vga_pkg`:
  - nominal timing constants (H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE, porch values) shared with the generator;
  - FSM state enum `cap_state_t`.
- Sub-module `vga_sync_edge`: 2-register synchroniser-style pipeline plus rising-edge pulse for one sync line, reset value 1, instantiated for hsync and vsync.

## Test plan
- Clean 640x480 raster with rgb=(x+y)%64 for 4 frames → `locked` at 2nd vsync edge +2 cycles; 307200 `pix_valid` per frame; every `pix_rgb` equals (pix_x+pix_y)%64.
- Locked stream → `frame_start` high exactly once per frame, with pix_x=0, pix_y=0, pix_valid=1; last pixel of the frame is (639,479).
- One 801-clock line in frame 3 → `sync_err` single pulse, `line_period`=801, `locked`=0. Relocks after the next clean check frame.
- Frame with 524 lines → `sync_err` at that vsync edge, FSM in HUNT; a following clean raster relocks after 2 vsync edges.
- hsync held high for 1700 clocks while locked → timeout at hcnt=1600, `locked`=0, `sync_err` pulse.
- `rst_pix_n` low mid-line while locked → all outputs 0 immediately. Release with raster running → no spurious edge, relock as in the first scenario.
